// File: rtl/cp0_if.sv
// M-stage coprocessor-0 bus: mtc0/mfc0 access, victim info, interrupt lines,
// and the req/epc_out results that steer the pipeline.
interface cp0_if;
   logic        en;
   logic [4:0]  cp0_addr;
   logic [31:0] cp0_wdata;
   logic [31:0] cp0_rdata;
   logic [31:0] vpc;
   logic        bd_in;
   logic [4:0]  exc_code_in;
   logic [5:0]  hw_int;
   logic        eret;
   logic        req;
   logic [31:0] epc_out;

   modport master (
      output en, cp0_addr, cp0_wdata, vpc, bd_in, exc_code_in, hw_int, eret,
      input  cp0_rdata, req, epc_out
   );

   modport slave (
      input  en, cp0_addr, cp0_wdata, vpc, bd_in, exc_code_in, hw_int, eret,
      output cp0_rdata, req, epc_out
   );
endinterface

// File: rtl/cp0_unit.sv
// Coprocessor-0 for the M stage: SR/Cause/EPC/PRId, mtc0/mfc0 access,
// interrupt/exception arbitration and the EPC target for eret.
module cp0_unit #(
   parameter logic [31:0] PRID = 32'h0000_0715
) (
   input logic clk,
   input logic reset,
   cp0_if.slave bus
);
   localparam logic [4:0] ADDR_SR    = 5'd12;
   localparam logic [4:0] ADDR_CAUSE = 5'd13;
   localparam logic [4:0] ADDR_EPC   = 5'd14;
   localparam logic [4:0] ADDR_PRID  = 5'd15;

   logic [5:0]  sr_im;
   logic        sr_exl;
   logic        sr_ie;
   logic        cause_bd;
   logic [5:0]  cause_ip;
   logic [4:0]  cause_exc;
   logic [31:0] epc;

   logic int_req;
   logic exc_req;
   logic req;

   // EXL masks both sources, so there is never a nested exception.
   always_comb begin
      int_req = (|(bus.hw_int & sr_im)) & sr_ie & ~sr_exl;
      exc_req = (bus.exc_code_in != 5'd0) & ~sr_exl;
      req     = int_req | exc_req;
   end

   assign bus.req = req;

   always_comb begin
      bus.cp0_rdata = 32'd0;
      case (bus.cp0_addr)
         ADDR_SR:    bus.cp0_rdata = {16'd0, sr_im, 8'd0, sr_exl, sr_ie};
         ADDR_CAUSE: bus.cp0_rdata = {cause_bd, 15'd0, cause_ip, 3'd0, cause_exc, 2'd0};
         ADDR_EPC:   bus.cp0_rdata = epc;
         ADDR_PRID:  bus.cp0_rdata = PRID;
         default:    bus.cp0_rdata = 32'd0;
      endcase
   end

   // Bypass lets an eret decoded upstream see an EPC write still sitting in M.
   always_comb begin
      bus.epc_out = epc;
      if (bus.en && (bus.cp0_addr == ADDR_EPC) && !req)
         bus.epc_out = bus.cp0_wdata;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sr_im     <= 6'd0;
         sr_exl    <= 1'b0;
         sr_ie     <= 1'b0;
         cause_bd  <= 1'b0;
         cause_ip  <= 6'd0;
         cause_exc <= 5'd0;
         epc       <= 32'd0;
      end else begin
         cause_ip <= bus.hw_int;
         if (req) begin
            // The victim's own mtc0 is dropped here.
            sr_exl    <= 1'b1;
            cause_exc <= int_req ? 5'd0 : bus.exc_code_in;
            cause_bd  <= bus.bd_in;
            epc       <= bus.bd_in ? (bus.vpc - 32'd4) : bus.vpc;
         end else if (bus.eret) begin
            sr_exl <= 1'b0;
         end else if (bus.en) begin
            if (bus.cp0_addr == ADDR_SR) begin
               sr_im  <= bus.cp0_wdata[15:10];
               sr_exl <= bus.cp0_wdata[1];
               sr_ie  <= bus.cp0_wdata[0];
            end else if (bus.cp0_addr == ADDR_EPC) begin
               epc <= bus.cp0_wdata;
            end
         end
      end
   end
endmodule

// File: tb/tb_cp0_unit.sv
// Bench for cp0_unit: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a word-level register model.
module tb_cp0_unit;
   localparam logic [31:0] PRID = 32'h0000_0715;

   logic clk = 1'b0;
   logic reset = 1'b1;
   cp0_if bus ();

   cp0_unit #(.PRID(PRID)) dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Model state as architectural words.
   logic [31:0] m_sr, m_cause, m_epc;
   bit model_valid = 1'b0;

   function automatic bit m_int_req();
      return ((bus.hw_int & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
   endfunction

   function automatic bit m_req();
      return m_int_req() || ((bus.exc_code_in != 5'd0) && !m_sr[1]);
   endfunction

   function automatic logic [31:0] m_read(input logic [4:0] a);
      case (a)
         5'd12:   return m_sr;
         5'd13:   return m_cause;
         5'd14:   return m_epc;
         5'd15:   return PRID;
         default: return 32'd0;
      endcase
   endfunction

   always @(posedge clk) begin
      bit r, ir;
      if (reset) begin
         m_sr = 0; m_cause = 0; m_epc = 0;
      end else begin
         r  = m_req();
         ir = m_int_req();
         m_cause[15:10] = bus.hw_int;
         if (r) begin
            m_sr[1] = 1'b1;
            m_cause[6:2] = ir ? 5'd0 : bus.exc_code_in;
            m_cause[31] = bus.bd_in;
            m_epc = bus.vpc - (bus.bd_in ? 32'd4 : 32'd0);
         end else if (bus.eret) begin
            m_sr[1] = 1'b0;
         end else if (bus.en) begin
            if (bus.cp0_addr == 5'd12) m_sr = bus.cp0_wdata & 32'h0000_FC03;
            else if (bus.cp0_addr == 5'd14) m_epc = bus.cp0_wdata;
         end
      end
      model_valid = 1'b1;
   end

   always @(negedge clk) begin
      logic [31:0] e_epc;
      if (model_valid) begin
         e_epc = (bus.en && bus.cp0_addr == 5'd14 && !m_req()) ? bus.cp0_wdata : m_epc;
         checks++;
         if (bus.req !== m_req()) begin
            failures++;
            $display("FAIL model_req t=%0t got=%b exp=%b", $time, bus.req, m_req());
         end
         checks++;
         if (bus.cp0_rdata !== m_read(bus.cp0_addr)) begin
            failures++;
            $display("FAIL model_rdata t=%0t addr=%0d got=%h exp=%h", $time,
                     bus.cp0_addr, bus.cp0_rdata, m_read(bus.cp0_addr));
         end
         checks++;
         if (bus.epc_out !== e_epc) begin
            failures++;
            $display("FAIL model_epc_out t=%0t got=%h exp=%h", $time, bus.epc_out, e_epc);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", name, act, exp);
      end
   endtask

   task automatic idle();
      bus.en = 0; bus.cp0_addr = 5'd0; bus.cp0_wdata = 0; bus.vpc = 0;
      bus.bd_in = 0; bus.exc_code_in = 0; bus.hw_int = 0; bus.eret = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
      bus.en = 1; bus.cp0_addr = a; bus.cp0_wdata = d;
      tick();
      bus.en = 0;
   endtask

   task automatic rd(input string name, input logic [4:0] a, input logic [31:0] exp);
      bus.cp0_addr = a;
      @(negedge clk);
      chk(name, bus.cp0_rdata, exp);
      tick();
   endtask

   initial begin
      idle();
      tick(); tick();
      reset = 0;

      // Reset state.
      rd("rst_sr", 5'd12, 32'd0);
      rd("rst_cause", 5'd13, 32'd0);
      rd("rst_epc", 5'd14, 32'd0);
      rd("rst_prid", 5'd15, PRID);
      rd("rst_unmapped", 5'd7, 32'd0);
      bus.hw_int = 6'h3F;
      @(negedge clk); chk("rst_req_masked", {31'd0, bus.req}, 32'd0);
      tick();
      bus.hw_int = 0;

      // Enabled interrupt.
      mtc0(5'd12, 32'h0000_0401);
      bus.hw_int = 6'h01; bus.vpc = 32'h3010;
      @(negedge clk); chk("int_req", {31'd0, bus.req}, 32'd1);
      tick();
      @(negedge clk); chk("int_req_exl_held", {31'd0, bus.req}, 32'd0);
      rd("int_epc", 5'd14, 32'h3010);
      rd("int_cause", 5'd13, 32'h0000_0400);
      rd("int_sr", 5'd12, 32'h0000_0403);
      bus.hw_int = 0;
      bus.eret = 1; tick(); bus.eret = 0;
      rd("eret_sr", 5'd12, 32'h0000_0401);

      // Exception in delay slot with interrupts disabled.
      mtc0(5'd12, 32'd0);
      bus.exc_code_in = 5'd12; bus.vpc = 32'h3020; bus.bd_in = 1;
      @(negedge clk); chk("exc_req", {31'd0, bus.req}, 32'd1);
      tick();
      bus.exc_code_in = 0; bus.bd_in = 0;
      rd("exc_epc", 5'd14, 32'h301C);
      rd("exc_cause", 5'd13, 32'h8000_0030);
      bus.eret = 1; tick(); bus.eret = 0;

      // Interrupt beats exception; same-cycle EPC write discarded.
      mtc0(5'd12, 32'h0000_0401);
      bus.hw_int = 6'h01; bus.exc_code_in = 5'd4; bus.vpc = 32'h5000;
      bus.en = 1; bus.cp0_addr = 5'd14; bus.cp0_wdata = 32'hDEAD_0000;
      @(negedge clk); chk("prio_epc_out_no_bypass", bus.epc_out, 32'h301C);
      tick();
      bus.en = 0; bus.exc_code_in = 0;
      rd("prio_epc", 5'd14, 32'h5000);
      rd("prio_cause", 5'd13, 32'h0000_0400);

      // eret + en + req together: only the req update.
      bus.hw_int = 0;
      bus.eret = 1; tick(); bus.eret = 0;
      bus.hw_int = 6'h01; bus.vpc = 32'h6000; bus.eret = 1;
      bus.en = 1; bus.cp0_addr = 5'd12; bus.cp0_wdata = 32'd0;
      tick();
      bus.eret = 0; bus.en = 0; bus.hw_int = 0;
      rd("combo_sr", 5'd12, 32'h0000_0403);
      rd("combo_epc", 5'd14, 32'h6000);
      bus.eret = 1; tick(); bus.eret = 0;

      // EPC write bypass and ignored Cause write.
      bus.en = 1; bus.cp0_addr = 5'd14; bus.cp0_wdata = 32'h4000;
      @(negedge clk); chk("bypass_epc_out", bus.epc_out, 32'h4000);
      tick(); bus.en = 0;
      rd("bypass_epc", 5'd14, 32'h4000);
      mtc0(5'd13, 32'hFFFF_FFFF);
      rd("cause_ro", 5'd13, 32'h0000_0000);

      // vpc wrap.
      bus.exc_code_in = 5'd1; bus.vpc = 32'd0; bus.bd_in = 1;
      tick();
      bus.exc_code_in = 0; bus.bd_in = 0;
      rd("wrap_epc", 5'd14, 32'hFFFF_FFFC);

      // Reset mid-handler clears EXL.
      reset = 1; tick(); reset = 0;
      rd("midrst_sr", 5'd12, 32'd0);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         reset = ($urandom_range(0, 199) == 0);
         bus.en = ($urandom_range(0, 3) == 0);
         bus.cp0_addr = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                                    : 5'($urandom_range(12, 15));
         bus.cp0_wdata = $urandom();
         bus.vpc = $urandom();
         bus.bd_in = $urandom_range(0, 1);
         bus.exc_code_in = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
         bus.hw_int = ($urandom_range(0, 3) == 0) ? 6'($urandom()) : 6'd0;
         bus.eret = ($urandom_range(0, 5) == 0);
         tick();
      end
      reset = 0;
      idle();
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
